// File: rtl/chess_pkg.sv
// Shared chess definitions used by the move sequencer and its rule checker.
//   piece_t  : 4-bit piece code (0 empty, 1-6 white, 7-C black, D-F invalid/empty)
//   square_t : 6-bit board square {row[2:0], col[2:0]}
//   WHITE/BLACK : side-to-move encoding
//   is_white / is_black / same_colour : colour helpers (invalid codes have no colour)
package chess_pkg;

    typedef enum logic [3:0] {
        EMPTY    = 4'h0,
        W_PAWN   = 4'h1,
        W_BISHOP = 4'h2,
        W_KNIGHT = 4'h3,
        W_ROOK   = 4'h4,
        W_QUEEN  = 4'h5,
        W_KING   = 4'h6,
        B_PAWN   = 4'h7,
        B_BISHOP = 4'h8,
        B_KNIGHT = 4'h9,
        B_ROOK   = 4'hA,
        B_QUEEN  = 4'hB,
        B_KING   = 4'hC,
        INV_D    = 4'hD,
        INV_E    = 4'hE,
        INV_F    = 4'hF
    } piece_t;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } square_t;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    function automatic logic is_white(input piece_t p);
        return (p >= W_PAWN) && (p <= W_KING);
    endfunction

    function automatic logic is_black(input piece_t p);
        return (p >= B_PAWN) && (p <= B_KING);
    endfunction

    // Empty and invalid codes never share a colour with anything.
    function automatic logic same_colour(input piece_t a, input piece_t b);
        return (is_white(a) && is_white(b)) || (is_black(a) && is_black(b));
    endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Bundle of the move request/response handshake and the board store ports.
//   move_valid/move_ready/move_from/move_to : move request from the game FSM
//   move_done/move_err/captured_code/turn    : move result toward the game FSM
//   rd_pos/rd_code                           : combinational board read port
//   figure_position/figure_code              : board write address and code
//   place_piece/remove_piece                 : one-cycle board write strobes
// Modport slave is the sequencer; modport master is its environment.
interface move_sequencer_if #(
    parameter int CODE_W = 5
);
    logic              move_valid;
    logic              move_ready;
    logic [5:0]        move_from;
    logic [5:0]        move_to;
    logic [5:0]        rd_pos;
    logic [3:0]        rd_code;
    logic [5:0]        figure_position;
    logic [CODE_W-1:0] figure_code;
    logic              place_piece;
    logic              remove_piece;
    logic              move_done;
    logic              move_err;
    logic [3:0]        captured_code;
    logic              turn;

    modport slave (
        input  move_valid, move_from, move_to, rd_code,
        output move_ready, rd_pos, figure_position, figure_code,
               place_piece, remove_piece, move_done, move_err,
               captured_code, turn
    );

    modport master (
        output move_valid, move_from, move_to, rd_code,
        input  move_ready, rd_pos, figure_position, figure_code,
               place_piece, remove_piece, move_done, move_err,
               captured_code, turn
    );
endinterface

// File: rtl/move_rules_check.sv
// Combinational legality check for one move.
//   src_code, dst_code : pieces on the source and destination squares
//   from, to           : source and destination squares
//   turn               : side to move (WHITE/BLACK)
//   legal              : move may be executed
//   capture            : legal move lands on an opposing piece
// Optional build macro TURN_CHECK_EN: when defined, only the side to move
// may move; otherwise either colour may move.
module move_rules_check
    import chess_pkg::*;
(
    input  piece_t  src_code,
    input  piece_t  dst_code,
    input  square_t from,
    input  square_t to,
    input  logic    turn,
    output logic    legal,
    output logic    capture
);

`ifdef TURN_CHECK_EN
    localparam logic TURN_FREE = 1'b0;
`else
    localparam logic TURN_FREE = 1'b1;
`endif

    logic src_occupied;
    logic dst_occupied;
    logic turn_ok;

    assign src_occupied = is_white(src_code) || is_black(src_code);
    assign dst_occupied = is_white(dst_code) || is_black(dst_code);
    // Colour of the moving piece must match the side to move (BLACK==1).
    assign turn_ok      = TURN_FREE || (is_black(src_code) == turn);

    assign legal   = (from != to) && src_occupied &&
                     !same_colour(src_code, dst_code) && turn_ok;
    assign capture = legal && dst_occupied;

endmodule

// File: rtl/move_sequencer.sv
// Move controller for the 8x8 board store. Accepts one (from, to) request,
// reads both squares, checks legality, then strobes remove (source) and
// place (destination) into the store and reports done/error upstream.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : move_sequencer_if.slave (request, result and board store signals)
// Optional build macro TURN_CHECK_EN (applied in move_rules_check): reject
// moves of the colour that is not on turn.
module move_sequencer
    import chess_pkg::*;
#(
    parameter int CODE_W = 5
) (
    input logic             clk,
    input logic             rst,
    move_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_SRC,
        RD_DST,
        CHECK,
        CLR_SRC,
        PUT_DST,
        RESP
    } state_t;

    state_t  state, state_nxt;
    square_t from_q, to_q;
    piece_t  src_q, dst_q, cap_q;
    logic    ok_q;
    logic    turn_q;
    logic [5:0] rd_pos_q;
    logic    legal, capture;

    move_rules_check u_rules (
        .src_code (src_q),
        .dst_code (dst_q),
        .from     (from_q),
        .to       (to_q),
        .turn     (turn_q),
        .legal    (legal),
        .capture  (capture)
    );

    // rd_pos is registered so that it already points at the source square in
    // RD_SRC, moves to the destination for RD_DST, and then simply holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            turn_q   <= WHITE;
            cap_q    <= EMPTY;
            rd_pos_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.move_valid) begin
                        from_q   <= square_t'(bus.move_from);
                        to_q     <= square_t'(bus.move_to);
                        rd_pos_q <= bus.move_from;
                        cap_q    <= EMPTY;
                    end
                end
                RD_SRC: begin
                    src_q    <= piece_t'(bus.rd_code);
                    rd_pos_q <= to_q;
                end
                RD_DST:  dst_q <= piece_t'(bus.rd_code);
                CHECK:   ok_q  <= legal;
                PUT_DST: begin
                    // Invalid destination codes count as empty, so nothing is captured.
                    cap_q  <= capture ? dst_q : EMPTY;
                    turn_q <= ~turn_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt           = state;
        bus.move_ready      = 1'b0;
        bus.remove_piece    = 1'b0;
        bus.place_piece     = 1'b0;
        bus.figure_position = '0;
        bus.figure_code     = '0;
        bus.move_done       = 1'b0;
        bus.move_err        = 1'b0;
        case (state)
            IDLE: begin
                bus.move_ready = 1'b1;
                if (bus.move_valid) state_nxt = RD_SRC;
            end
            RD_SRC: state_nxt = RD_DST;
            RD_DST: state_nxt = CHECK;
            CHECK:  state_nxt = legal ? CLR_SRC : RESP;
            CLR_SRC: begin
                bus.remove_piece    = 1'b1;
                bus.figure_position = from_q;
                state_nxt           = PUT_DST;
            end
            PUT_DST: begin
                bus.place_piece     = 1'b1;
                bus.figure_position = to_q;
                bus.figure_code     = CODE_W'(src_q);
                state_nxt           = RESP;
            end
            RESP: begin
                // RESP is reached from PUT_DST on success or CHECK on rejection.
                bus.move_done = ok_q;
                bus.move_err  = ~ok_q;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.rd_pos        = rd_pos_q;
    assign bus.captured_code = cap_q;
    assign bus.turn          = turn_q;

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Move controller for the 8x8 board store. It accepts one move request at a time as a (from, to) square pair. It reads both squares through the board's combinational read port, checks ownership and capture rules, and then drives the store's single-square remove/place strobes in sequence. It also tracks the side to move and reports each result to the game FSM upstream.

## Interface
Parameters:
- `CODE_W`, default 5: width of `figure_code` toward the board store. Bits above [3:0] are always 0.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `move_valid` in 1: a move request is present.
- `move_ready` out 1: sequencer is idle and can accept a request.
- `move_from` in 6: source square; [5:3] is the row, [2:0] is the column.
- `move_to` in 6: destination square, same encoding as `move_from`.
- `rd_pos` out 6: square address driven to the board read port.
- `rd_code` in 4: piece code at `rd_pos`, combinational, valid in the same cycle.
- `figure_position` out 6: write address to the board store.
- `figure_code` out CODE_W: piece code to write.
- `place_piece` out 1: write-strobe, one cycle.
- `remove_piece` out 1: clear-strobe, one cycle.
- `move_done` out 1: one-cycle pulse when a move has been executed.
- `move_err` out 1: one-cycle pulse when a move is rejected.
- `captured_code` out 4: code of the captured piece, or 0 when nothing was captured. Valid while `move_done` is high and held until the next request is accepted.
- `turn` out 1: side to move; 0 is white, 1 is black.

## Operation
- Piece encoding:
  - 0: empty.
  - 1–6: white pawn, bishop, knight, rook, queen, king.
  - 7–C: black, same order.
  - D–F: invalid, treated as empty.
  - Colour of code c: white if 1≤c≤6, black if 7≤c≤C.
- FSM states: IDLE, RD_SRC, RD_DST, CHECK, CLR_SRC, PUT_DST, RESP.
- IDLE:
  - `move_ready`=1.
  - On `move_valid` & `move_ready`: latch `move_from` and `move_to`, clear `captured_code`, go to RD_SRC.
- RD_SRC: `rd_pos`=from; latch `rd_code` into src_code.
- RD_DST: `rd_pos`=to; latch `rd_code` into dst_code.
- CHECK: the move is rejected if any of these holds:
  - from == to;
  - src_code is empty;
  - src_code and dst_code are the same colour;
  - the `TURN_CHECK_EN` rule below fails.
  - Rejected: go to RESP with error.
  - Accepted: go to CLR_SRC.
- CLR_SRC: `remove_piece`=1, `figure_position`=from.
- PUT_DST:
  - `place_piece`=1, `figure_position`=to, `figure_code`=src_code.
  - This overwrites any captured piece.
  - `captured_code`<=dst_code.
  - `turn` toggles.
- RESP:
  - Pulse `move_done` on success, or `move_err` on rejection.
  - Return to IDLE.
- Only legality checks are performed (emptiness, ownership, self-capture). Piece movement geometry is the upstream block's responsibility.
- `rd_pos` outside RD_SRC/RD_DST holds the last driven value. `figure_position`/`figure_code` are 0 when no strobe is active.

## Timing
- Reset values:
  - state=IDLE, `turn`=0, `captured_code`=0.
  - `move_done`, `move_err`, `place_piece`, `remove_piece` all 0.
  - `rd_pos`, `figure_position`, `figure_code` all 0.
  - `move_ready`=1 in the first cycle after reset.
- Accept cycle is T.
- Legal move:
  - RD_SRC at T+1, RD_DST at T+2, CHECK at T+3.
  - `remove_piece` at T+4, `place_piece` at T+5.
  - `move_done` at T+6.
  - `move_ready` high again at T+7.
- Illegal move: `move_err` at T+4; `move_ready` at T+5.
- `move_valid` while `move_ready`=0 is ignored. No queuing.
- `remove_piece` and `place_piece` are never high in the same cycle.
- `move_done` and `move_err` are never high in the same cycle.
- Reset in any state:
  - Next cycle is IDLE with no strobe and `turn`=0.
  - A half-done move (source cleared, destination not yet written) is abandoned.
  - The board store is expected to be reset on the same `rst`.
- Inputs `move_from`/`move_to` are sampled only at acceptance. Later changes have no effect.

## Configuration
- `TURN_CHECK_EN` defined:
  - CHECK also rejects the move when the colour of src_code ≠ `turn`.
- `TURN_CHECK_EN` undefined:
  - Either colour may move.
  - `turn` still toggles on every successful move and is informational only.

## Structure
- Shared package `chess_pkg` holds:
  - `piece_t`, a 4-bit enum of the codes above;
  - `square_t`, a 6-bit packed struct {row[2:0], col[2:0]};
  - the constants `WHITE`=0 and `BLACK`=1;
  - the functions `is_white(piece_t)`, `is_black(piece_t)` and `same_colour(piece_t, piece_t)`.
- One combinational sub-module, `move_rules_check`, contains:
  - inputs: src_code, dst_code, from, to, `turn`;
  - outputs: legal, capture.
  - The turn rule inside it is gated by `TURN_CHECK_EN`.
- The FSM, registers and strobe generation stay in `move_sequencer`.

## Test plan
- Reset, then accept from=0x31, to=0x21 with rd model source=7 and destination=0.
  - Expect `remove_piece`@T+4 with pos 0x31.
  - Expect `place_piece`@T+5 with pos 0x21 and code 7.
  - Expect `move_done`@T+6, `captured_code`=0, `turn`=1.
- Capture: source=1, destination=9.
  - Expect `move_done`, `captured_code`=9, `place_piece` code=1.
  - Expect `turn` toggled.
- Rejections: source empty; source=4 with destination=2 (self-capture); from==to.
  - Each gives `move_err`@T+4, no strobes, `turn` unchanged.
- Turn rule: with `TURN_CHECK_EN` and `turn`=0, source=7.
  - Expect `move_err`.
  - Without the macro, the same stimulus gives `move_done`.
- Busy handling: hold `move_valid` high with a changing `move_to` during T+1..T+6.
  - The move uses the originally latched `move_to`.
  - A second request is accepted only at T+7.
- Reset asserted at T+4 (during CLR_SRC):
  - Next cycle shows IDLE, `move_ready`=1, no `place_piece`, `turn`=0.
